// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states,
// the default RAM size and the alignment helper used by the optional trap.
package lsu_pkg;

  localparam int unsigned MEM_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ST_RD = 3'd2,
    ST_WR = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input lsu_size_e size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo[1:0];
      SZ_D:    mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and RAM-side signal bundle of lsu_mem_ctrl.
// slave = the controller, master = MEM stage plus RAM model.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 64
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [63:0]       req_wdata_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [63:0]       resp_rdata_o;
  logic              resp_fault_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [63:0]       mem_wdata_o;
  logic              mem_wen_o;
  logic [63:0]       mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  resp_ready_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o,
    output mem_addr_o, mem_wdata_o, mem_wen_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output resp_ready_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o,
    input  mem_addr_o, mem_wdata_o, mem_wen_o
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational data alignment: load extract with sign/zero extension, and
// byte-merge of store data into the 8-byte RAM window read back for RMW.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        zext,
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merge_data
);

  // Size-selected extract/extend for loads and low-byte replace for stores.
  always_comb begin
    load_data  = 64'd0;
    merge_data = rdata;
    case (size)
      SZ_B: begin
        load_data  = {{56{~zext & rdata[7]}}, rdata[7:0]};
        merge_data = {rdata[63:8], wdata[7:0]};
      end
      SZ_H: begin
        load_data  = {{48{~zext & rdata[15]}}, rdata[15:0]};
        merge_data = {rdata[63:16], wdata[15:0]};
      end
      SZ_W: begin
        load_data  = {{32{~zext & rdata[31]}}, rdata[31:0]};
        merge_data = {rdata[63:32], wdata[31:0]};
      end
      SZ_D: begin
        load_data  = rdata;
        merge_data = wdata;
      end
      default: begin
        load_data  = 64'd0;
        merge_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the 64-bit byte-addressed data RAM (RMW for narrow stores).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses fault instead of proceeding.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lsu_mem_ctrl_if.slave      bus
);

  lsu_state_e        state_r, state_s;

  lsu_size_e         size_r;
  logic              zext_r;
  logic [ADDR_W-1:0] addr_r;
  logic [63:0]       wdata_r;

  // All outputs are registered; *_s is the value they take after the next edge.
  logic              req_ready_r,  req_ready_s;
  logic              resp_valid_r, resp_valid_s;
  logic [63:0]       resp_rdata_r, resp_rdata_s;
  logic              resp_fault_r, resp_fault_s;
  logic [ADDR_W-1:0] mem_addr_r,   mem_addr_s;
  logic [63:0]       mem_wdata_r,  mem_wdata_s;
  logic              mem_wen_r,    mem_wen_s;

  logic              accept_s;
  logic [ADDR_W:0]   end_addr_s;
  logic              misalign_s;
  logic              fault_s;
  logic [63:0]       load_data_s;
  logic [63:0]       merge_data_s;

  assign accept_s = bus.req_valid_i & req_ready_r;

  // One extra bit keeps the carry, so a wrapping addr+7 compares as out of range.
  assign end_addr_s = {1'b0, bus.req_addr_i} + (ADDR_W+1)'(7);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = is_misaligned(bus.req_addr_i[2:0], lsu_size_e'(bus.req_size_i));
`else
  assign misalign_s = 1'b0;
`endif

  assign fault_s = (end_addr_s >= (ADDR_W+1)'(MEM_BYTES)) | misalign_s;

  lsu_align u_align (
    .size       (size_r),
    .zext       (zext_r),
    .rdata      (bus.mem_rdata_i),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // Next state and next registered output values.
  always_comb begin
    state_s      = state_r;
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    resp_rdata_s = resp_rdata_r;
    resp_fault_s = resp_fault_r;
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_wdata_s  = 64'd0;
    mem_wen_s    = 1'b0;
    case (state_r)
      IDLE: begin
        resp_rdata_s = 64'd0;
        resp_fault_s = 1'b0;
        if (accept_s) begin
          if (fault_s) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_fault_s = 1'b1;
          end else if (bus.req_we_i) begin
            state_s    = ST_RD;
            mem_addr_s = bus.req_addr_i;
          end else begin
            state_s    = LOAD;
            mem_addr_s = bus.req_addr_i;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      LOAD: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
        resp_rdata_s = load_data_s;
      end
      // The merged window is produced here so ST_WR drives it from a register.
      ST_RD: begin
        state_s     = ST_WR;
        mem_addr_s  = addr_r;
        mem_wdata_s = merge_data_s;
        mem_wen_s   = 1'b1;
      end
      ST_WR: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
      end
      RESP: begin
        if (bus.resp_ready_i) begin
          state_s      = IDLE;
          req_ready_s  = 1'b1;
          resp_rdata_s = 64'd0;
          resp_fault_s = 1'b0;
        end else begin
          resp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s      = IDLE;
        req_ready_s  = 1'b1;
        resp_rdata_s = 64'd0;
        resp_fault_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops mem_wen_o without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 64'd0;
      resp_fault_r <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= 64'd0;
      mem_wen_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_fault_r <= resp_fault_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      mem_wen_r    <= mem_wen_s;
    end
  end

  // Request capture at accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      size_r  <= SZ_B;
      zext_r  <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= 64'd0;
    end else if (accept_s) begin
      size_r  <= lsu_size_e'(bus.req_size_i);
      zext_r  <= bus.req_unsigned_i;
      addr_r  <= bus.req_addr_i;
      wdata_r <= bus.req_wdata_i;
    end
  end

  assign bus.req_ready_o  = req_ready_r;
  assign bus.resp_valid_o = resp_valid_r;
  assign bus.resp_rdata_o = resp_rdata_r;
  assign bus.resp_fault_o = resp_fault_r;
  assign bus.mem_addr_o   = mem_addr_r;
  assign bus.mem_wdata_o  = mem_wdata_r;
  assign bus.mem_wen_o    = mem_wen_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Table-driven bench for lsu_mem_ctrl with a byte-array RAM model (1024 bytes).
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int unsigned ADDR_W = 64;
  localparam int          NV     = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_mem_ctrl #(.MEM_BYTES(1024), .ADDR_W(ADDR_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.mem_wen_o && bus.mem_addr_o <= 64'd1016) begin
      for (int i = 0; i < 8; i++) ram[bus.mem_addr_o[9:0] + 10'(i)] <= bus.mem_wdata_o[8*i +: 8];
    end
  end

  always_comb begin
    bus.mem_rdata_i = 64'd0;
    if (bus.mem_addr_o <= 64'd1016) begin
      for (int i = 0; i < 8; i++) bus.mem_rdata_i[8*i +: 8] = ram[bus.mem_addr_o[9:0] + 10'(i)];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        zext;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_wen;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic zx,
                              input logic [63:0] a, input logic [63:0] w, input logic [63:0] er,
                              input logic ef, input int el, input int ew);
    vec_t v;
    v.we = we; v.size = sz; v.zext = zx; v.addr = a; v.wdata = w;
    v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el; v.exp_wen = ew;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic do_req(input int idx, input vec_t v, input int hold);
    int lat;
    int wens;
    @(negedge clk);
    check("req_ready_before", idx, 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = v.we;
    bus.req_size_i     = v.size;
    bus.req_unsigned_i = v.zext;
    bus.req_addr_i     = v.addr;
    bus.req_wdata_i    = v.wdata;
    bus.resp_ready_i   = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    lat  = 1;
    wens = bus.mem_wen_o ? 1 : 0;
    while (!bus.resp_valid_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.mem_wen_o) wens++;
    end
    check("rdata", idx, bus.resp_rdata_o, v.exp_rdata);
    check("fault", idx, 64'(bus.resp_fault_o), 64'(v.exp_fault));
    check("latency", idx, 64'(lat), 64'(v.exp_lat));
    check("wen_pulses", idx, 64'(wens), 64'(v.exp_wen));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", idx, 64'(bus.resp_valid_o), 64'd1);
      check("hold_rdata", idx, bus.resp_rdata_o, v.exp_rdata);
      check("hold_ready", idx, 64'(bus.req_ready_o), 64'd0);
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
    check("idle_after_resp", idx, {62'd0, bus.req_ready_o, bus.resp_valid_o}, 64'd2);
  endtask

  initial begin
    logic [63:0] win;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 64'd0; bus.req_wdata_i = 64'd0;
    bus.resp_ready_i = 1'b0;

    vecs[0]  = mk(1'b1, 2'd3, 1'b0, 64'h20,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 3, 1);
    vecs[1]  = mk(1'b1, 2'd3, 1'b0, 64'h3F8, 64'h5A5A_5A5A_5A5A_5A00, 64'd0, 1'b0, 3, 1);
    vecs[2]  = mk(1'b1, 2'd3, 1'b0, 64'h10,  64'h1122_3344_5566_7788, 64'd0, 1'b0, 3, 1);
    vecs[3]  = mk(1'b0, 2'd3, 1'b0, 64'h10,  64'd0, 64'h1122_3344_5566_7788, 1'b0, 2, 0);
    vecs[4]  = mk(1'b1, 2'd0, 1'b0, 64'h20,  64'h0000_0000_0000_00A5, 64'd0, 1'b0, 3, 1);
    vecs[5]  = mk(1'b0, 2'd3, 1'b0, 64'h20,  64'd0, 64'hFFFF_FFFF_FFFF_FFA5, 1'b0, 2, 0);
    vecs[6]  = mk(1'b1, 2'd0, 1'b0, 64'h30,  64'hDEAD_BEEF_0000_0080, 64'd0, 1'b0, 3, 1);
    vecs[7]  = mk(1'b0, 2'd0, 1'b0, 64'h30,  64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 0);
    vecs[8]  = mk(1'b0, 2'd0, 1'b1, 64'h30,  64'd0, 64'h0000_0000_0000_0080, 1'b0, 2, 0);
    vecs[9]  = mk(1'b1, 2'd2, 1'b0, 64'h40,  64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0, 3, 1);
    vecs[10] = mk(1'b0, 2'd2, 1'b0, 64'h40,  64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 2, 0);
    vecs[11] = mk(1'b0, 2'd2, 1'b1, 64'h40,  64'd0, 64'h0000_0000_8000_0000, 1'b0, 2, 0);
    vecs[12] = mk(1'b1, 2'd1, 1'b0, 64'h50,  64'h1111_2222_3333_8234, 64'd0, 1'b0, 3, 1);
    vecs[13] = mk(1'b0, 2'd1, 1'b0, 64'h50,  64'd0, 64'hFFFF_FFFF_FFFF_8234, 1'b0, 2, 0);
    vecs[14] = mk(1'b0, 2'd1, 1'b1, 64'h50,  64'd0, 64'h0000_0000_0000_8234, 1'b0, 2, 0);
    vecs[15] = mk(1'b0, 2'd3, 1'b1, 64'h20,  64'd0, 64'hFFFF_FFFF_FFFF_FFA5, 1'b0, 2, 0);
    vecs[16] = mk(1'b0, 2'd3, 1'b0, 64'h3F8, 64'd0, 64'h5A5A_5A5A_5A5A_5A00, 1'b0, 2, 0);
    vecs[17] = mk(1'b0, 2'd3, 1'b0, 64'h3F9, 64'd0, 64'd0, 1'b1, 1, 0);
    vecs[18] = mk(1'b1, 2'd3, 1'b0, 64'h3F9, 64'd0, 64'd0, 1'b1, 1, 0);
    vecs[19] = mk(1'b0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 1'b1, 1, 0);
    vecs[20] = mk(1'b0, 2'd0, 1'b0, 64'h3FF, 64'd0, 64'd0, 1'b1, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[21] = mk(1'b0, 2'd1, 1'b0, 64'h11,  64'd0, 64'd0, 1'b1, 1, 0);
`else
    vecs[21] = mk(1'b0, 2'd1, 1'b0, 64'h11,  64'd0, 64'h0000_0000_0000_6677, 1'b0, 2, 0);
`endif

    // Reset state, observed before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_req_ready", 0, 64'(bus.req_ready_o), 64'd1);
    check("rst_resp_valid", 0, 64'(bus.resp_valid_o), 64'd0);
    check("rst_resp_rdata", 0, bus.resp_rdata_o, 64'd0);
    check("rst_resp_fault", 0, 64'(bus.resp_fault_o), 64'd0);
    check("rst_mem_addr", 0, bus.mem_addr_o, 64'd0);
    check("rst_mem_wdata", 0, bus.mem_wdata_o, 64'd0);
    check("rst_mem_wen", 0, 64'(bus.mem_wen_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) do_req(i, vecs[i], 0);

    // RAM contents after the RMW stores and the faulting store.
    check("ram_byte_store", 32, 64'(ram[10'h20]), 64'hA5);
    for (int i = 1; i < 8; i++) check("ram_byte_kept", 32 + i, 64'(ram[10'h20 + 10'(i)]), 64'hFF);
    check("ram_byte_neighbor", 49, 64'(ram[10'h31]), 64'h00);
    for (int i = 1; i < 8; i++) check("ram_fault_untouched", 1016 + i, 64'(ram[10'h3F8 + 10'(i)]), 64'h5A);

    // Backpressure: response held stable for 5 cycles.
    do_req(50, vecs[3], 5);

    // Reset in ST_WR: the write pulse must die before the next edge.
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd3;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 64'h60; bus.req_wdata_i = 64'hCAFE_F00D_CAFE_F00D;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("st_wr_wen_high", 60, 64'(bus.mem_wen_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_wen", 60, 64'(bus.mem_wen_o), 64'd0);
    check("rst_async_ready", 60, 64'(bus.req_ready_o), 64'd1);
    check("rst_async_addr", 60, bus.mem_addr_o, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) win[8*i +: 8] = ram[10'h60 + 10'(i)];
    check("ram_no_partial_write", 60, win, 64'd0);
    do_req(61, mk(1'b0, 2'd3, 1'b0, 64'h60, 64'd0, 64'd0, 1'b0, 2, 0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
